// File: rtl/wb_cfg_master.sv
// wb_cfg_master: Wishbone classic single-access master for the MAC register port.
//
// Turns a valid/ready command stream into one Wishbone access at a time and
// returns a valid/ready response. A bus access that is not acknowledged
// within TIMEOUT_CYCLES strobe cycles is abandoned and reported with rsp_err.
//
// Parameters:
//   ADDR_W         Wishbone address width
//   DATA_W         Wishbone data width
//   TIMEOUT_CYCLES strobe cycles to wait for wb_ack_i (1..65535)
//   INT_PEND_ADDR  interrupt-pending register address (interrupt service only)
//
// Ports:
//   wb_clk_i, wb_rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_we, cmd_addr, cmd_wdata         command payload
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_err                  response payload (rdata 0 on write/timeout)
//   wb_cyc_o, wb_stb_o, wb_we_o         Wishbone control
//   wb_adr_o, wb_dat_o, wb_dat_i        Wishbone address / data
//   wb_ack_i, wb_int_i                  Wishbone acknowledge / level interrupt
//   int_pend_valid, int_pend            interrupt-pending read result (optional)
//
// Optional feature macro: WB_CFG_MASTER_INT_SERVICE_EN
//   When defined, a rising edge of wb_int_i triggers an autonomous read of
//   INT_PEND_ADDR whose result is pulsed on int_pend_valid/int_pend.
//   When undefined, wb_int_i is ignored and the int_pend ports do not exist.

module wb_cfg_master #(
    parameter int unsigned       ADDR_W         = 8,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [ADDR_W-1:0] INT_PEND_ADDR  = ADDR_W'(8'h08)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_int_i
`ifdef WB_CFG_MASTER_INT_SERVICE_EN
    ,
    output logic              int_pend_valid,
    output logic [DATA_W-1:0] int_pend
`endif
);

    localparam int unsigned      CNT_W    = 16;
    // Last strobe cycle index that may still complete without a timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              cyc_q;
    logic              cyc_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] adr_nxt;
    logic [DATA_W-1:0] dat_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              err_nxt;
    logic              cmd_ready_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              auto_q;     // current access is an autonomous interrupt read
    logic              auto_nxt;

    logic              start_cmd;
    logic              start_int;
    logic              bus_ack;
    logic              bus_timeout;

`ifdef WB_CFG_MASTER_INT_SERVICE_EN
    logic              int_q;
    logic              int_req;
    logic              int_req_nxt;
    logic              int_rise;
    logic              int_pend_valid_nxt;
    logic [DATA_W-1:0] int_pend_nxt;

    assign int_rise    = wb_int_i & ~int_q;
    // Launching a service read consumes the latched request; a new edge re-arms it.
    assign start_int   = (state == IDLE) && int_req;
    assign int_req_nxt = (int_req & ~start_int) | int_rise;
`else
    logic unused_int;
    assign unused_int = wb_int_i;
    assign start_int  = 1'b0;
`endif

    assign start_cmd   = (state == IDLE) && cmd_valid && cmd_ready;
    assign bus_ack     = (state == BUS) && wb_ack_i;
    // Ack has priority over the timeout boundary in the same cycle.
    assign bus_timeout = (state == BUS) && !wb_ack_i && (cnt_q == CNT_LAST);

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_cmd || start_int) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (bus_ack || bus_timeout) begin
                    state_nxt = auto_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of all registered outputs.
    always_comb begin
        cyc_nxt       = cyc_q;
        we_nxt        = wb_we_o;
        adr_nxt       = wb_adr_o;
        dat_nxt       = wb_dat_o;
        rsp_valid_nxt = rsp_valid;
        rdata_nxt     = rsp_rdata;
        err_nxt       = rsp_err;
        cnt_nxt       = cnt_q;
        auto_nxt      = auto_q;
`ifdef WB_CFG_MASTER_INT_SERVICE_EN
        cmd_ready_nxt      = (state_nxt == IDLE) && !int_req_nxt;
        int_pend_valid_nxt = 1'b0;
        int_pend_nxt       = int_pend;
`else
        cmd_ready_nxt      = (state_nxt == IDLE);
`endif

        case (state)
            IDLE: begin
                if (start_cmd) begin
                    cyc_nxt  = 1'b1;
                    we_nxt   = cmd_we;
                    adr_nxt  = cmd_addr;
                    dat_nxt  = cmd_we ? cmd_wdata : '0;
                    cnt_nxt  = '0;
                    auto_nxt = 1'b0;
                end else if (start_int) begin
                    cyc_nxt  = 1'b1;
                    we_nxt   = 1'b0;
                    adr_nxt  = INT_PEND_ADDR;
                    dat_nxt  = '0;
                    cnt_nxt  = '0;
                    auto_nxt = 1'b1;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    cyc_nxt = 1'b0;
                    we_nxt  = 1'b0;
                    if (!auto_q) begin
                        rsp_valid_nxt = 1'b1;
                        rdata_nxt     = wb_we_o ? '0 : wb_dat_i;
                        err_nxt       = 1'b0;
                    end
`ifdef WB_CFG_MASTER_INT_SERVICE_EN
                    else begin
                        int_pend_valid_nxt = 1'b1;
                        int_pend_nxt       = wb_dat_i;
                    end
`endif
                end else if (bus_timeout) begin
                    cyc_nxt = 1'b0;
                    we_nxt  = 1'b0;
                    // A timed-out service read is silently dropped.
                    if (!auto_q) begin
                        rsp_valid_nxt = 1'b1;
                        rdata_nxt     = '0;
                        err_nxt       = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                cyc_nxt = 1'b0;
                we_nxt  = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cyc_q     <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            cnt_q     <= '0;
            auto_q    <= 1'b0;
        end else begin
            cyc_q     <= cyc_nxt;
            wb_we_o   <= we_nxt;
            wb_adr_o  <= adr_nxt;
            wb_dat_o  <= dat_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
            cmd_ready <= cmd_ready_nxt;
            cnt_q     <= cnt_nxt;
            auto_q    <= auto_nxt;
        end
    end

`ifdef WB_CFG_MASTER_INT_SERVICE_EN
    // Interrupt edge detect, pending request and result registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            int_q          <= 1'b0;
            int_req        <= 1'b0;
            int_pend_valid <= 1'b0;
            int_pend       <= '0;
        end else begin
            int_q          <= wb_int_i;
            int_req        <= int_req_nxt;
            int_pend_valid <= int_pend_valid_nxt;
            int_pend       <= int_pend_nxt;
        end
    end
`endif

endmodule

// File: doc/wb_cfg_master.md
Name: wb_cfg_master

Overview:
- Wishbone classic single-access master that drives the MAC's register slave interface: wb_* address, data, strobe and cycle outputs, with acknowledge and interrupt inputs.
- Sits between a local command source (bench sequencer or management CPU shim) and the MAC Wishbone port.
- Turns command/response handshakes into bus cycles, with an ack timeout so a hung bus never locks up the command source.

Parameters:
- ADDR_W, 8, Wishbone address width.
- DATA_W, 32, Wishbone data width.
- TIMEOUT_CYCLES, 255, bus cycles to wait for wb_ack_i before aborting; legal range 1..65535.
- INT_PEND_ADDR, 8'h08, address of the MAC interrupt-pending register; used only by the optional feature.

Ports:
- wb_clk_i  in  1  sole clock; all logic is on the rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present; held until it is taken.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = access timed out.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_W  address.
- wb_dat_o  out  DATA_W  write data.
- wb_dat_i  in  DATA_W  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_int_i  in  1  slave interrupt, level.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0 except cmd_ready = 1. Asserting reset mid-access drops wb_cyc_o/wb_stb_o asynchronously and discards any pending response.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On a handshake at cycle N: latch we/addr/wdata to wb_we_o/wb_adr_o/wb_dat_o (wb_dat_o = 0 for reads), set wb_cyc_o = wb_stb_o = 1 at N+1, clear the timeout counter, go to BUS. cmd_ready = 0 from N+1.
- BUS:
  - Counter increments each cycle while wb_ack_i = 0.
  - If wb_ack_i = 1 at cycle M: capture wb_dat_i into rsp_rdata for reads (0 for writes), rsp_err = 0, drop cyc/stb/we at M+1, rsp_valid = 1 at M+1, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no ack: drop cyc/stb next cycle, rsp_err = 1, rsp_rdata = 0, rsp_valid = 1, go to RESP.
  - If ack and the timeout boundary occur in the same cycle, ack wins (rsp_err = 0).
  - wb_ack_i outside BUS is ignored.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the handshake: rsp_valid = 0 and cmd_ready = 1 next cycle, return to IDLE.
- Back-to-back throughput: with rsp_ready tied high and immediate acks, one access every 3 cycles minimum. wb_stb_o is never asserted on two consecutive cycles across accesses.
- wb_adr_o, wb_dat_o and wb_we_o are stable for the whole BUS state.
- Only one outstanding access; no pipelining, no bursts.

Optional Feature:
- Macro WB_CFG_MASTER_INT_SERVICE_EN.
- Defined:
  - Adds outputs int_pend_valid (1) and int_pend (DATA_W).
  - A rising edge of wb_int_i seen in IDLE, or latched while busy, causes an autonomous read of INT_PEND_ADDR through BUS, using the same timeout rules.
  - An autonomous read has priority over cmd_valid in IDLE; cmd_ready = 0 that cycle.
  - Its result drives int_pend_valid as a 1-cycle pulse with int_pend = read data. It never appears on rsp_*.
  - On timeout, int_pend_valid is not pulsed and the latched request is dropped.
- Undefined: wb_int_i is unused, the extra ports are absent, and behaviour is exactly as above.

Test Plan:
- Write: cmd addr 8'h00, wdata 32'h0000_0001, slave acks 2 cycles after stb -> cyc/stb/we high for 2 cycles, wb_dat_o = 32'h1, rsp_valid = 1 with rsp_err = 0 and rsp_rdata = 0.
- Read: addr 8'h0C, slave returns 32'hA5A5_0003 with ack -> rsp_rdata = 32'hA5A5_0003, rsp_err = 0, stb low the cycle after ack.
- Timeout: TIMEOUT_CYCLES = 4, slave never acks -> stb high exactly 4 cycles, then rsp_err = 1 and rsp_rdata = 0; next command accepted normally.
- Backpressure: rsp_ready held 0 for 10 cycles after a read -> rsp_* stable, cmd_ready = 0, no new bus cycle even with cmd_valid = 1.
- Reset mid-access: wb_rst_n low while stb = 1 -> cyc/stb = 0 immediately, cmd_ready = 1 after release, no rsp_valid.
- WB_CFG_MASTER_INT_SERVICE_EN defined: pulse wb_int_i while a write is in BUS -> after the write response, a read of 8'h08 is issued; int_pend_valid pulses once with the slave data 32'h0000_0004.
